// File: rtl/y86_pipe_regs.sv
// Pipeline register bank (F/D/E/M/W) for the Y86-64 five-stage pipeline.
// Each stage loads, holds or takes a NOP. The bank also has a halt freeze, a sticky conflict flag and counters.
module y86_pipe_regs #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter logic [3:0]  BUBBLE_STAT = 4'h8,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      f_predpc,
  input  logic [147:0]     d_in,
  input  logic [219:0]     e_in,
  input  logic [144:0]     m_in,
  input  logic [143:0]     w_in,
  input  logic             F_stall,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic             E_bubble,
  input  logic             M_bubble,
  input  logic             W_stall,
  output logic [63:0]      F_predPC,
  output logic [147:0]     D_out,
  output logic [219:0]     E_out,
  output logic [144:0]     M_out,
  output logic [143:0]     W_out,
  output logic             halted,
  output logic             ctl_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [3:0] NOP_ICODE = 4'h1;
  localparam logic [3:0] RNONE     = 4'hF;

  // NOP images follow the same field layout as the corresponding *_in bus.
  localparam logic [147:0] D_NOP = {BUBBLE_STAT, NOP_ICODE, 4'h0, RNONE, RNONE, 64'h0, 64'h0};
  localparam logic [219:0] E_NOP = {BUBBLE_STAT, NOP_ICODE, 4'h0, 64'h0, 64'h0, 64'h0,
                                    RNONE, RNONE, RNONE, RNONE};
  localparam logic [144:0] M_NOP = {BUBBLE_STAT, NOP_ICODE, 1'b0, 64'h0, 64'h0, RNONE, RNONE};
  localparam logic [143:0] W_NOP = {BUBBLE_STAT, NOP_ICODE, 64'h0, 64'h0, RNONE, RNONE};

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic stall_any;
  logic bubble_any;
  logic w_err;

  assign stall_any  = F_stall | D_stall | W_stall;
  assign bubble_any = D_bubble | E_bubble | M_bubble;
  assign w_err      = |W_out[142:140];

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_predPC <= RESET_PC;
      D_out    <= D_NOP;
      E_out    <= E_NOP;
      M_out    <= M_NOP;
      W_out    <= W_NOP;
    end else if (!halted) begin
      if (!F_stall) F_predPC <= f_predpc;

      if (D_stall)       D_out <= D_out;
      else if (D_bubble) D_out <= D_NOP;
      else               D_out <= d_in;

      E_out <= E_bubble ? E_NOP : e_in;
      M_out <= M_bubble ? M_NOP : m_in;

      if (!W_stall) W_out <= w_in;
    end
  end

  // Halt is taken from the registered W stat, so the error stat is visible one edge before the freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted  <= 1'b0;
      ctl_err <= 1'b0;
    end else if (!halted) begin
      halted <= w_err;
      if (D_stall && D_bubble) ctl_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!halted) begin
      if (stall_any && !(&stall_cnt))   stall_cnt  <= stall_cnt + CNT_ONE;
      if (bubble_any && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_y86_pipe_regs.sv
// Randomized self-checking bench for y86_pipe_regs.
// A field-level reference model is stepped once per rising edge and compared against every output.
module tb_y86_pipe_regs;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_1000;
  localparam int          CNT_W    = 4;
  localparam int          CNT_MAX  = 15;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [63:0]        f_predpc = '0;
  logic [147:0]       d_in = '0;
  logic [219:0]       e_in = '0;
  logic [144:0]       m_in = '0;
  logic [143:0]       w_in = '0;
  logic               F_stall = 1'b0, D_stall = 1'b0, D_bubble = 1'b0;
  logic               E_bubble = 1'b0, M_bubble = 1'b0, W_stall = 1'b0;
  logic [63:0]        F_predPC;
  logic [147:0]       D_out;
  logic [219:0]       E_out;
  logic [144:0]       M_out;
  logic [143:0]       W_out;
  logic               halted, ctl_err;
  logic [CNT_W-1:0]   stall_cnt, bubble_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  y86_pipe_regs #(.RESET_PC(RESET_PC), .BUBBLE_STAT(4'h8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .f_predpc(f_predpc), .d_in(d_in), .e_in(e_in),
    .m_in(m_in), .w_in(w_in), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .W_stall(W_stall), .F_predPC(F_predPC), .D_out(D_out), .E_out(E_out),
    .M_out(M_out), .W_out(W_out), .halted(halted), .ctl_err(ctl_err),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state, held as whole stage images plus flags and integer counters.
  logic [63:0]  m_f;
  logic [147:0] m_d;
  logic [219:0] m_e;
  logic [144:0] m_m;
  logic [143:0] m_w;
  logic         m_halt, m_err;
  int           m_sc, m_bc;

  logic [730:0] act_all, exp_all;
  assign act_all = {F_predPC, D_out, E_out, M_out, W_out, halted, ctl_err, stall_cnt, bubble_cnt};
  assign exp_all = {m_f, m_d, m_e, m_m, m_w, m_halt, m_err, m_sc[3:0], m_bc[3:0]};

  function automatic logic [147:0] d_nop();
    return {4'h8, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0};
  endfunction
  function automatic logic [219:0] e_nop();
    return {4'h8, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF};
  endfunction
  function automatic logic [144:0] m_nop();
    return {4'h8, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF};
  endfunction
  function automatic logic [143:0] w_nop();
    return {4'h8, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF};
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_f = RESET_PC; m_d = d_nop(); m_e = e_nop(); m_m = m_nop(); m_w = w_nop();
    m_halt = 1'b0; m_err = 1'b0; m_sc = 0; m_bc = 0;
  endtask

  // Applies one clock edge of the stage rules to the model using the current inputs.
  task automatic model_edge();
    logic next_halt;
    if (m_halt) return;
    next_halt = (m_w[142:140] != 3'b000);
    if (!F_stall) m_f = f_predpc;
    if (!D_stall) m_d = D_bubble ? d_nop() : d_in;
    m_e = E_bubble ? e_nop() : e_in;
    m_m = M_bubble ? m_nop() : m_in;
    if (!W_stall) m_w = w_in;
    if (D_stall && D_bubble) m_err = 1'b1;
    if (F_stall || D_stall || W_stall) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
    if (D_bubble || E_bubble || M_bubble) m_bc = (m_bc < CNT_MAX) ? m_bc + 1 : CNT_MAX;
    m_halt = next_halt;
  endtask

  // Called at posedge+1; advances model and DUT by one edge, returns at the next posedge+1.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    F_stall = 0; D_stall = 0; D_bubble = 0; E_bubble = 0; M_bubble = 0; W_stall = 0;
  endtask

  task automatic rand_data(input logic [3:0] di, input logic [3:0] ei,
                           input logic [3:0] mi, input logic [3:0] wi);
    logic [255:0] r;
    f_predpc = {$urandom, $urandom};
    r = rnd256(); d_in = r[147:0]; d_in[147:144] = 4'h8; d_in[143:140] = di;
    r = rnd256(); e_in = r[219:0]; e_in[219:216] = 4'h8; e_in[215:212] = ei;
    r = rnd256(); m_in = r[144:0]; m_in[144:141] = 4'h8; m_in[140:137] = mi;
    r = rnd256(); w_in = r[143:0]; w_in[143:140] = 4'h8; w_in[139:136] = wi;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    clear_ctl();
    do_reset();
    tests_run++;
    if (act_all !== exp_all) begin
      tests_failed++;
      $display("FAIL reset_image act=%h exp=%h", act_all, exp_all);
    end
    tests_run++;
    if (F_predPC !== RESET_PC || D_out[143:140] !== 4'h1 || W_out[143:140] !== 4'h8) begin
      tests_failed++;
      $display("FAIL reset_fields pc=%h d_icode=%h w_stat=%h exp pc=%h 1 8",
               F_predPC, D_out[143:140], W_out[143:140], RESET_PC);
    end
  endtask

  task automatic test_load();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      rand_data(4'h2, 4'h3, 4'h6, 4'h5);
      step();
      tests_run++;
      if (act_all !== exp_all) begin
        tests_failed++;
        $display("FAIL load_%0d act=%h exp=%h", i, act_all, exp_all);
      end
      tests_run++;
      if (D_out !== d_in || E_out !== e_in || M_out !== m_in || W_out !== w_in ||
          F_predPC !== f_predpc) begin
        tests_failed++;
        $display("FAIL load_passthru_%0d d_icode=%h e_icode=%h m_icode=%h w_icode=%h exp 2 3 6 5",
                 i, D_out[143:140], E_out[215:212], M_out[140:137], W_out[139:136]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [63:0]  pc_prev;
    logic [147:0] d_prev;
    @(posedge clk); #1;
    do_reset();
    rand_data(4'h2, 4'h3, 4'h6, 4'h5);
    step();
    pc_prev = F_predPC; d_prev = D_out;
    rand_data(4'h2, 4'h3, 4'h6, 4'h5);
    F_stall = 1; D_stall = 1; E_bubble = 1;
    step();
    clear_ctl();
    tests_run++;
    if (act_all !== exp_all) begin
      tests_failed++;
      $display("FAIL load_use act=%h exp=%h", act_all, exp_all);
    end
    tests_run++;
    if (F_predPC !== pc_prev || D_out !== d_prev || E_out[215:212] !== 4'h1 ||
        E_out[15:8] !== 8'hFF || stall_cnt !== 4'd1 || bubble_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL load_use_fields e_icode=%h dst=%h sc=%0d bc=%0d exp 1 ff 1 1",
               E_out[215:212], E_out[15:8], stall_cnt, bubble_cnt);
    end
  endtask

  task automatic test_mispredict();
    int bc_before;
    @(posedge clk); #1;
    bc_before = bubble_cnt;
    rand_data(4'h7, 4'h7, 4'h2, 4'h3);
    D_bubble = 1; E_bubble = 1;
    step();
    clear_ctl();
    tests_run++;
    if (act_all !== exp_all) begin
      tests_failed++;
      $display("FAIL mispredict act=%h exp=%h", act_all, exp_all);
    end
    tests_run++;
    if (D_out !== d_nop() || E_out !== e_nop() || M_out !== m_in || W_out !== w_in ||
        int'(bubble_cnt) !== bc_before + 1) begin
      tests_failed++;
      $display("FAIL mispredict_fields d_icode=%h e_icode=%h bc=%0d exp 1 1 %0d",
               D_out[143:140], E_out[215:212], bubble_cnt, bc_before + 1);
    end
  endtask

  task automatic test_ctl_err();
    logic [147:0] d_prev;
    @(posedge clk); #1;
    d_prev = D_out;
    rand_data(4'h4, 4'h4, 4'h4, 4'h4);
    D_stall = 1; D_bubble = 1;
    step();
    clear_ctl();
    tests_run++;
    if (D_out !== d_prev || ctl_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ctl_err_set ctl_err=%b d_held=%b exp 1 1", ctl_err, D_out === d_prev);
    end
    for (int i = 0; i < 3; i++) begin
      rand_data(4'h2, 4'h3, 4'h6, 4'h5);
      step();
    end
    tests_run++;
    if (act_all !== exp_all || ctl_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ctl_err_sticky ctl_err=%b exp 1 act=%h exp=%h", ctl_err, act_all, exp_all);
    end
  endtask

  task automatic test_random();
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      rand_data($urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0),
                $urandom_range(15, 0));
      {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} = 6'($urandom_range(63, 0));
      step();
      tests_run++;
      if (act_all !== exp_all) begin
        tests_failed++;
        $display("FAIL random_%0d act=%h exp=%h", i, act_all, exp_all);
      end
    end
    clear_ctl();
  endtask

  task automatic test_halt();
    logic [730:0] snap;
    @(posedge clk); #1;
    do_reset();
    rand_data(4'h2, 4'h3, 4'h6, 4'h0);
    w_in[143:140] = 4'h4;
    step();
    tests_run++;
    if (W_out[143:140] !== 4'h4 || halted !== 1'b0 || act_all !== exp_all) begin
      tests_failed++;
      $display("FAIL halt_w_stat stat=%h halted=%b exp 4 0", W_out[143:140], halted);
    end
    step();
    tests_run++;
    if (halted !== 1'b1 || act_all !== exp_all) begin
      tests_failed++;
      $display("FAIL halt_set halted=%b exp 1", halted);
    end
    snap = act_all;
    for (int i = 0; i < 6; i++) begin
      rand_data(4'h2, 4'h3, 4'h6, 4'h5);
      {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall} = 6'($urandom_range(63, 0));
      step();
    end
    clear_ctl();
    tests_run++;
    if (act_all !== snap || act_all !== exp_all) begin
      tests_failed++;
      $display("FAIL halt_freeze act=%h exp=%h", act_all, exp_all);
    end
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    do_reset();
    F_stall = 1;
    for (int i = 0; i < 20; i++) begin
      rand_data(4'h2, 4'h3, 4'h6, 4'h5);
      step();
      if (i == 14) begin
        tests_run++;
        if (stall_cnt !== 4'hF) begin
          tests_failed++;
          $display("FAIL sat_reach stall_cnt=%h exp f", stall_cnt);
        end
      end
    end
    clear_ctl();
    tests_run++;
    if (stall_cnt !== 4'hF || act_all !== exp_all) begin
      tests_failed++;
      $display("FAIL sat_nowrap stall_cnt=%h exp f", stall_cnt);
    end
    // Mid-cycle reset pulse: outputs must drop to the reset image before any edge.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (act_all !== exp_all || stall_cnt !== 4'h0 || F_predPC !== RESET_PC) begin
      tests_failed++;
      $display("FAIL async_reset act=%h exp=%h", act_all, exp_all);
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_load_use();
    test_mispredict();
    test_ctl_err();
    test_random();
    test_halt();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
